uart_apb_bridge: RTL

APB initiator driven by a UART byte stream: the bridge sits behind the UART receiver and in front of the UART transmitter. It turns command frames from the host into single APB read/write transfers on the peripheral bus, and returns status and read data as response bytes. It is the bus-master counterpart of the APB slave interface of the uart peripheral, letting a host poke any APB slave over the serial line.

---
 rtl/uart_apb_bridge.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: decodes command frames arriving from a UART receiver into
// single APB transfers and streams status/read data back to a UART
// transmitter. A command is 'W' + 4 address + 4 data bytes or 'R' + 4 address
// bytes, always MSB first. The response is 'K' (plus 4 read-data bytes on a
// read), 'E' on a slave error or APB timeout, and '?' for an unknown opcode.
module uart_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int BYTE_TO = 100000,
  parameter int APB_TO  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] RSP_UNK  = 8'h3F;

  localparam int BT_W = $clog2(BYTE_TO + 1);
  localparam int AT_W = $clog2(APB_TO + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TO - 1);
  localparam logic [BT_W-1:0] BT_ONE  = BT_W'(1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(APB_TO - 1);
  localparam logic [AT_W-1:0] AT_ONE  = AT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    SETUP  = 3'd3,
    ACCESS = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     addr_sr;     // full 4-byte address field; upper bits may be dropped
  logic [1:0]      field_cnt;   // byte index inside the current 4-byte field
  logic [BT_W-1:0] byte_cnt;    // idle cycles since the last accepted frame byte
  logic [AT_W-1:0] apb_cnt;     // ACCESS cycles spent waiting for pready
  logic [39:0]     resp_buf;    // pending response bytes, next byte in the top octet
  logic [2:0]      resp_cnt;    // response bytes still to be handed to the transmitter
  logic            rx_fire;
  logic            tx_fire;
  logic            is_opcode;
  logic            byte_timeout;
  logic            apb_timeout;
  logic            apb_done;
  logic            apb_ok;

  // Response word for a finished APB transfer: 'K' (+ read data) or 'E'.
  function automatic logic [39:0] resp_frame(input logic ok, input logic is_read,
                                             input logic [31:0] rdata);
    logic [39:0] f;
    if (!ok) begin
      f = {RSP_ERR, 32'h0000_0000};
    end else if (is_read) begin
      f = {RSP_OK, rdata};
    end else begin
      f = {RSP_OK, 32'h0000_0000};
    end
    return f;
  endfunction

  assign paddr        = addr_sr[ADDR_W-1:0];
  assign tx_data      = resp_buf[39:32];
  assign rx_fire      = rx_valid & rx_ready;
  assign tx_fire      = tx_valid & tx_ready;
  assign is_opcode    = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign byte_timeout = (byte_cnt == BT_LAST);
  assign apb_timeout  = (apb_cnt == AT_LAST);
  assign apb_done     = pready | apb_timeout;
  assign apb_ok       = pready & ~pslverr;

  // Handshake and bus-phase outputs decoded from the registered state.
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        rx_ready = ~rst;
        busy     = 1'b0;
      end
      ADDR:    rx_ready = ~rst;
      DATA:    rx_ready = ~rst;
      SETUP:   psel     = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP:    tx_valid = 1'b1;
      default: busy     = 1'b1;
    endcase
  end

  // Next-state logic for the frame/transfer/response sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_fire) begin
          state_nxt = is_opcode ? ADDR : RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR: begin
        if (rx_fire) begin
          if (field_cnt == 2'd3) begin
            state_nxt = pwrite ? DATA : SETUP;
          end else begin
            state_nxt = ADDR;
          end
        end else if (byte_timeout) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ADDR;
        end
      end
      DATA: begin
        if (rx_fire) begin
          state_nxt = (field_cnt == 2'd3) ? SETUP : DATA;
        end else if (byte_timeout) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (apb_done) begin
          state_nxt = RESP;
        end else begin
          state_nxt = ACCESS;
        end
      end
      RESP: begin
        if (tx_fire && (resp_cnt == 3'd1)) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Inter-byte timeout counter, only running while a frame is half received.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (rx_fire || !((state == ADDR) || (state == DATA))) begin
      byte_cnt <= '0;
    end else begin
      byte_cnt <= byte_cnt + BT_ONE;
    end
  end

  // Byte position inside the address or data field; wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      field_cnt <= 2'd0;
    end else if (!((state == ADDR) || (state == DATA))) begin
      field_cnt <= 2'd0;
    end else if (rx_fire) begin
      field_cnt <= field_cnt + 2'd1;
    end else begin
      field_cnt <= field_cnt;
    end
  end

  // Opcode direction, address and write data capture; frozen outside the
  // receive states so the bus sees stable values through the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwrite  <= 1'b0;
      addr_sr <= 32'h0000_0000;
      pwdata  <= 32'h0000_0000;
    end else if (rx_fire) begin
      case (state)
        IDLE: begin
          if (is_opcode) begin
            pwrite <= (rx_data == OP_WRITE);
          end else begin
            pwrite <= pwrite;
          end
        end
        ADDR:    addr_sr <= {addr_sr[23:0], rx_data};
        DATA:    pwdata  <= {pwdata[23:0], rx_data};
        default: pwrite  <= pwrite;
      endcase
    end else begin
      pwrite <= pwrite;
    end
  end

  // APB wait-state counter; cleared whenever the bus is not in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      apb_cnt <= '0;
    end else if (state == ACCESS) begin
      apb_cnt <= apb_cnt + AT_ONE;
    end else begin
      apb_cnt <= '0;
    end
  end

  // Response buffer: loaded on an unknown opcode or at the end of a transfer,
  // then shifted one byte per transmitter handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_buf <= 40'h00_0000_0000;
      resp_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fire && !is_opcode) begin
            resp_buf <= {RSP_UNK, 32'h0000_0000};
            resp_cnt <= 3'd1;
          end else begin
            resp_cnt <= resp_cnt;
          end
        end
        ACCESS: begin
          if (apb_done) begin
            resp_buf <= resp_frame(apb_ok, ~pwrite, prdata);
            resp_cnt <= (apb_ok && !pwrite) ? 3'd5 : 3'd1;
          end else begin
            resp_cnt <= resp_cnt;
          end
        end
        RESP: begin
          if (tx_fire) begin
            resp_buf <= {resp_buf[31:0], 8'h00};
            resp_cnt <= resp_cnt - 3'd1;
          end else begin
            resp_cnt <= resp_cnt;
          end
        end
        default: resp_cnt <= resp_cnt;
      endcase
    end
  end

endmodule
